// File: rtl/uart_pkg.sv
// Shared UART types and limits.
// Used by the transmitter and its baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  localparam int UART_MAX_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1.
// Tick is issued on the terminal count while enabled.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;

  assign tick = enable &&
    (r_cnt == CW'(CLKS_PER_BIT - 1));

  // Bit-period counter, restarted on clear and at wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with valid/ready input.
// Optional line break: define UART_TX_CFG_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [UART_MAX_DATA_BITS-1:0] tx_data,
`ifdef UART_TX_CFG_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done,
  output logic       busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam parity_t PMODE =
    parity_t'(PARITY_MODE[1:0]);
  localparam logic [UART_MAX_DATA_BITS-1:0] DMASK =
    UART_MAX_DATA_BITS'((1 << DATA_BITS) - 1);

  if (DATA_BITS < 5 ||
      DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_db
    $error("uart_tx_cfg: DATA_BITS must be 5..8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY_MODE must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_cfg: STOP_BITS must be 1..2");
  end

  tx_state_t r_state, w_state;
  logic [UART_MAX_DATA_BITS-1:0] r_shift, w_shift;
  logic [BW-1:0] r_bit, w_bit;
  logic r_tx, w_tx;
  logic r_done, w_done;
  logic r_par, w_par;
  logic w_tick;
  logic w_accept;

  assign busy     = (r_state != IDLE);
  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign w_accept = tx_valid && tx_ready;

`ifdef UART_TX_CFG_BREAK_EN
  logic r_brk;

  // Remembers a break seen last cycle so accept waits one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_brk <= 1'b0;
    else      r_brk <= (r_state == IDLE) && tx_break;
  end

  assign tx_ready = (r_state == IDLE) &&
    !tx_break && !r_brk;
`else
  assign tx_ready = (r_state == IDLE);
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .enable(busy),
    .tick  (w_tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_tx    <= w_tx;
      r_done  <= w_done;
      r_par   <= w_par;
    end
  end

  // Next state, next line level and frame bookkeeping.
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_tx    = r_tx;
    w_done  = 1'b0;
    w_par   = r_par;
    unique case (r_state)
      IDLE: begin
`ifdef UART_TX_CFG_BREAK_EN
        w_tx = !tx_break;
`else
        w_tx = 1'b1;
`endif
        if (w_accept) begin
          w_state = START;
          w_tx    = 1'b0;
          w_shift = tx_data;
          w_bit   = '0;
          w_par   = (^(tx_data & DMASK)) ^
                    (PMODE == PAR_ODD);
        end
      end
      START: begin
        if (w_tick) begin
          w_state = DATA;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == BW'(DATA_BITS - 1)) begin
            w_bit = '0;
            if (PMODE != PAR_NONE) begin
              w_state = PARITY;
              w_tx    = r_par;
            end else begin
              w_state = STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit   = r_bit + BW'(1);
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state = STOP;
          w_tx    = 1'b1;
          w_bit   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit == BW'(STOP_BITS - 1)) begin
            w_state = IDLE;
            w_done  = 1'b1;
            w_bit   = '0;
          end else begin
            w_bit = r_bit + BW'(1);
          end
          w_tx = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg over four configurations.
// Break scenario runs when UART_TX_CFG_BREAK_EN is defined.
module tb_uart_tx_cfg;

  localparam int NI  = 4;
  localparam int CPB = 4;
  localparam int DBA [NI] = '{8, 8, 8, 5};
  localparam int PMA [NI] = '{0, 1, 2, 0};
  localparam int SBA [NI] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0] v   = '0;
  logic [7:0]    d [NI];
  logic [NI-1:0] rdy, txo, dn, bsy;
`ifdef UART_TX_CFG_BREAK_EN
  logic [NI-1:0] brk = '0;
`endif

  int total = 0;
  int bad   = 0;
  bit q[$];
  bit ok;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_cfg #(
      .DATA_BITS   (DBA[g]),
      .CLKS_PER_BIT(CPB),
      .PARITY_MODE (PMA[g]),
      .STOP_BITS   (SBA[g])
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(v[g]),
      .tx_data (d[g]),
`ifdef UART_TX_CFG_BREAK_EN
      .tx_break(brk[g]),
`endif
      .tx_ready(rdy[g]),
      .tx      (txo[g]),
      .tx_done (dn[g]),
      .busy    (bsy[g])
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected serial bits for one frame, start to last stop.
  task automatic sb_push(input int k, input logic [7:0] data);
    logic p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < DBA[k]; i++) begin
      q.push_back(data[i]);
      p = p ^ data[i];
    end
    if (PMA[k] == 1) q.push_back(p);
    if (PMA[k] == 2) q.push_back(~p);
    for (int i = 0; i < SBA[k]; i++) q.push_back(1'b1);
  endtask

  // Called 1 time unit after the accept edge; returns in the done cycle.
  task automatic sb_drain(input int k, input string tag);
    bit b;
    int bi;
    int badc;
    logic [2:0] seen;
    bi = 0;
    while (q.size() > 0) begin
      b = q.pop_front();
      badc = 0;
      seen = 3'b000;
      for (int c = 0; c < CPB; c++) begin
        if (txo[k] !== b || bsy[k] !== 1'b1 ||
            dn[k] !== 1'b0) begin
          if (badc == 0) seen = {txo[k], bsy[k], dn[k]};
          badc++;
        end
        @(posedge clk); #1;
      end
      total++;
      if (badc != 0) begin
        bad++;
        $display("FAIL %s bit%0d: tx/busy/done=%b required %b%b0 for %0d clk",
                 tag, bi, seen, b, 1'b1, CPB);
      end
      bi++;
    end
    total++;
    if ({dn[k], bsy[k], txo[k], rdy[k]} !== 4'b1011) begin
      bad++;
      $display("FAIL %s end: done/busy/tx/ready=%b required 1011",
               tag, {dn[k], bsy[k], txo[k], rdy[k]});
    end
  endtask

  // Raise valid at a negedge, wait (bounded) for the accept edge.
  task automatic do_accept(input int k, input logic [7:0] data,
                           output bit okk);
    @(negedge clk);
    v[k] = 1'b1;
    d[k] = data;
    okk = 1'b0;
    for (int n = 0; n < 200 && !okk; n++) begin
      if (rdy[k] === 1'b1) okk = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!okk) begin
      bad++;
      $display("FAIL accept%0d: ready never 1, required accept", k);
    end
  endtask

  task automatic test_reset();
    v = '0;
    for (int i = 0; i < NI; i++) d[i] = 8'h00;
    rst = 1'b0;
    #12;
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({txo[i], bsy[i], dn[i], rdy[i]} !== 4'b1001) begin
        bad++;
        $display("FAIL reset%0d: tx/busy/done/ready=%b required 1001",
                 i, {txo[i], bsy[i], dn[i], rdy[i]});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    do_accept(0, 8'hA5, ok);
    v[0] = 1'b0;
    d[0] = 8'h00;
    sb_push(0, 8'hA5);
    sb_drain(0, "8n1_a5");
    @(posedge clk); #1;
    total++;
    if (dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL 8n1_pulse: done=%b required 0", dn[0]);
    end
  endtask

  task automatic test_parity();
    do_accept(1, 8'h07, ok);
    v[1] = 1'b0;
    sb_push(1, 8'h07);
    sb_drain(1, "par_even");
    do_accept(2, 8'h07, ok);
    v[2] = 1'b0;
    sb_push(2, 8'h07);
    sb_drain(2, "par_odd");
  endtask

  task automatic test_narrow();
    do_accept(3, 8'hFF, ok);
    v[3] = 1'b0;
    sb_push(3, 8'hFF);
    sb_drain(3, "5n2_ff");
    do_accept(3, 8'hE0, ok);
    v[3] = 1'b0;
    sb_push(3, 8'hE0);
    sb_drain(3, "5n2_e0");
  endtask

  task automatic test_back_to_back();
    do_accept(0, 8'h55, ok);
    d[0] = 8'h3C;
    sb_push(0, 8'h55);
    sb_drain(0, "b2b_first");
    sb_push(0, 8'h3C);
    @(posedge clk); #1;
    v[0] = 1'b0;
    sb_drain(0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    do_accept(0, 8'hA5, ok);
    v[0] = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    total++;
    if ({txo[0], bsy[0]} !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_pre: tx/busy=%b required 01",
               {txo[0], bsy[0]});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({txo[0], bsy[0], dn[0], rdy[0]} !== 4'b1001) begin
      bad++;
      $display("FAIL rstmid_async: tx/busy/done/ready=%b required 1001",
               {txo[0], bsy[0], dn[0], rdy[0]});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({txo[0], bsy[0], dn[0]} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid_hold: tx/busy/done=%b required 100",
               {txo[0], bsy[0], dn[0]});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_nodone: done=%b required 0", dn[0]);
    end
    do_accept(0, 8'h3C, ok);
    v[0] = 1'b0;
    sb_push(0, 8'h3C);
    sb_drain(0, "rstmid_fresh");
  endtask

`ifdef UART_TX_CFG_BREAK_EN
  task automatic test_break();
    int lows;
    int leak;
    lows = 0;
    leak = 0;
    @(negedge clk);
    brk[0] = 1'b1;
    v[0]   = 1'b1;
    d[0]   = 8'h5A;
    repeat (20) begin
      @(posedge clk); #1;
      if (txo[0] === 1'b0) lows++;
      if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) leak++;
    end
    total++;
    if (lows != 20 || leak != 0) begin
      bad++;
      $display("FAIL break_hold: low=%0d leak=%0d required 20 and 0",
               lows, leak);
    end
    @(negedge clk);
    brk[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({txo[0], bsy[0], rdy[0]} !== 3'b101) begin
      bad++;
      $display("FAIL break_release: tx/busy/ready=%b required 101",
               {txo[0], bsy[0], rdy[0]});
    end
    @(posedge clk); #1;
    v[0] = 1'b0;
    sb_push(0, 8'h5A);
    sb_drain(0, "break_frame");
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_narrow();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_CFG_BREAK_EN
    test_break();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
